// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 encodings and decode helpers for the load/store unit
package lsu_pkg;

  localparam int LSU_XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only have signed-looking encodings; unsigned variants are loads only.
  function automatic logic lsu_illegal_f3(input logic write, input logic [2:0] funct3);
    if (write) begin
      return funct3[2] || (funct3 == 3'b011);
    end
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  endfunction

  function automatic logic lsu_needs_read(input logic write, input logic [2:0] funct3);
    return !write || (funct3 != F3_W);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane extract/extend for loads and lane merge for sub-word stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]          funct3_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [LSU_XLEN-1:0] word_i,
  input  logic [15:0]         wdata_i,
  output logic [LSU_XLEN-1:0] load_data_o,
  output logic [LSU_XLEN-1:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_off;
  logic [4:0]  half_off;

  // Halfword lane ignores addr[0] so unaligned halves fold onto their containing half.
  assign byte_off = {addr_lo_i, 3'b000};
  assign half_off = {addr_lo_i[1], 4'b0000};

  always_comb begin
    byte_sel    = word_i[byte_off +: 8];
    half_sel    = word_i[half_off +: 16];
    load_data_o = word_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_o = {24'h000000, byte_sel};
      F3_HU:   load_data_o = {16'h0000, half_sel};
      default: load_data_o = word_i;
    endcase
  end

  always_comb begin
    store_word_o = word_i;
    case (funct3_i[1:0])
      2'b00:   store_word_o[byte_off +: 8]  = wdata_i[7:0];
      2'b01:   store_word_o[half_off +: 16] = wdata_i;
      default: store_word_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit with sub-word read-modify-write; LSU_MISALIGN_TRAP_EN enables misalignment faults
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  lsu_state_e            state_q;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic [15:0]           wdata_q;
  logic                  resp_valid_q;
  logic                  resp_fault_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_write_data_q;

  logic                  req_fault;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  always_comb begin
    req_fault = lsu_illegal_f3(req_write, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
      req_fault = 1'b1;
    end
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
      req_fault = 1'b1;
    end
`endif
  end

  lsu_align u_align (
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_lo_q),
    .word_i       (mem_read_data),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      write_q          <= 1'b0;
      funct3_q         <= F3_B;
      addr_lo_q        <= 2'b00;
      wdata_q          <= '0;
      resp_valid_q     <= 1'b0;
      resp_fault_q     <= 1'b0;
      resp_rdata_q     <= '0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            if (req_fault) begin
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= '0;
              state_q      <= S_RESP;
            end else begin
              mem_addr_q <= {req_addr[DATA_WIDTH-1:2], 2'b00};
              if (lsu_needs_read(req_write, req_funct3)) begin
                state_q <= S_READ;
              end else begin
                mem_write_data_q <= req_wdata;
                state_q          <= S_WRITE;
              end
            end
          end
        end
        S_READ: begin
          if (write_q) begin
            mem_write_data_q <= store_word;
            state_q          <= S_WRITE;
          end else begin
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= load_data;
            state_q      <= S_RESP;
          end
        end
        S_WRITE: begin
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= '0;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  // The write strobe is gated by rst combinationally so a reset landing in WRITE suppresses the store.
  assign mem_write_enable = (state_q == S_WRITE) && !rst;
  assign req_ready        = (state_q == S_IDLE) && !rst;
  assign resp_valid       = resp_valid_q;
  assign resp_fault       = resp_fault_q;
  assign resp_rdata       = resp_rdata_q;
  assign mem_addr         = mem_addr_q;
  assign mem_write_data   = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic        tb_init;
  logic [31:0] mem [0:15];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  assign mem_read_data = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h80402011;
      mem[5] <= 32'h11111111;
    end else if (mem_write_enable) begin
      mem[mem_addr[5:2]] <= mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic exp_fault, input logic [31:0] exp_rdata,
                     input int exp_nw, input logic [31:0] exp_wdat);
    int          lat;
    int          nw;
    int          wcyc;
    logic        flt;
    logic [31:0] rdata;
    logic [31:0] wdat;
    logic [31:0] waddr;
    lat = 0; nw = 0; wcyc = 0; flt = 1'bx; rdata = 'x; wdat = 'x; waddr = 'x;
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_write_enable) begin
        nw++; wcyc = c; wdat = mem_write_data; waddr = mem_addr;
      end
      if (resp_valid) begin
        lat = c; flt = resp_fault; rdata = resp_rdata;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_fault"}, {31'b0, flt}, {31'b0, exp_fault});
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_nwrite"}, nw, exp_nw);
    if (exp_nw > 0) begin
      check({tag, "_wdata"}, wdat, exp_wdat);
      check({tag, "_waddr"}, waddr, {addr[31:2], 2'b00});
      check({tag, "_wcyc"}, wcyc, exp_lat - 1);
    end
  endtask

  initial begin
    rst = 1'b1; tb_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_mem_we", {31'b0, mem_write_enable}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0; tb_init = 1'b0;

    run("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h80402011, 0, 32'h0);
    run("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFF80, 0, 32'h0);
    run("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 1'b0, 32'h00000080, 0, 32'h0);
    run("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF8040, 0, 32'h0);
    run("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 2, 1'b0, 32'h00002011, 0, 32'h0);
    run("lb11",  1'b0, 3'b000, 32'h11, 32'h0, 2, 1'b0, 32'h00000020, 0, 32'h0);

    run("sb11",  1'b1, 3'b000, 32'h11, 32'h000000AB, 3, 1'b0, 32'h0, 1, 32'h8040AB11);
    run("lw_sb", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h8040AB11, 0, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    run("sh11",  1'b1, 3'b001, 32'h11, 32'h00001234, 1, 1'b1, 32'h0, 0, 32'h0);
    run("lw_sh", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h8040AB11, 0, 32'h0);
    run("lw16",  1'b0, 3'b010, 32'h16, 32'h0, 1, 1'b1, 32'h0, 0, 32'h0);
`else
    run("sh11",  1'b1, 3'b001, 32'h11, 32'h00001234, 3, 1'b0, 32'h0, 1, 32'h80401234);
    run("lw_sh", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h80401234, 0, 32'h0);
    run("lw16",  1'b0, 3'b010, 32'h16, 32'h0, 2, 1'b0, 32'h11111111, 0, 32'h0);
`endif

    run("sw18",  1'b1, 3'b010, 32'h18, 32'hCAFEF00D, 2, 1'b0, 32'h0, 1, 32'hCAFEF00D);
    run("lw18",  1'b0, 3'b010, 32'h18, 32'h0, 2, 1'b0, 32'hCAFEF00D, 0, 32'h0);
    run("sbu_bad", 1'b1, 3'b100, 32'h18, 32'h55, 1, 1'b1, 32'h0, 0, 32'h0);

    // SW aborted by reset during its WRITE cycle
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("abort_we", {31'b0, mem_write_enable}, 32'd0);
    check("abort_ready_in_rst", {31'b0, req_ready}, 32'd0);
    check("abort_resp_in_rst", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_resp_after", {31'b0, resp_valid}, 32'd0);
    check("abort_ready_after", {31'b0, req_ready}, 32'd1);
    check("abort_we_after", {31'b0, mem_write_enable}, 32'd0);
    run("lw14",  1'b0, 3'b010, 32'h14, 32'h0, 2, 1'b0, 32'h11111111, 0, 32'h0);

    run("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'h0, 0, 32'h0);
    run("lw_b2b", 1'b0, 3'b010, 32'h18, 32'h0, 2, 1'b0, 32'hCAFEF00D, 0, 32'h0);
    run("ld110", 1'b0, 3'b110, 32'h10, 32'h0, 1, 1'b1, 32'h0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
